collision_scan_engine: RTL and testbench
========================================

// Module: collision_scan_engine
// PURPOSE
//  Sequential, parametrised successor to the single-block overlap judge. On START it snapshots
//  the player square and NUM_BLOCKS obstacle slots. It then evaluates one slot per clock against
//  the shape gap table. It reports the first hit, the hit count and an optional sticky game-over flag.
//  Sits between the obstacle scroller and the game-state FSM; runs once per video frame.
// PARAMETERS
//  NUM_BLOCKS   8    obstacle slots scanned per request (1..16)
//  COORD_W      10   coordinate width (pixels)
//  SIZE_W       6    square size width
//  SHAPE_W      4    shape code width
//  MAX_GAPS     2    free vertical gaps per shape in the table
//  BLOCK_W      40   obstacle width in pixels
//  EARLY_EXIT   0    1: stop the scan at the first hit
//  STICKY       1    1: HIT stays set across scans until CLEAR_STICKY
// PORTS
//  CLK           in   1                  system clock
//  RST_N         in   1                  asynchronous active-low reset
//  START         in   1                  scan request pulse; honoured only when idle
//  SQUARE_X      in   COORD_W            square left edge
//  SQUARE_Y      in   COORD_W            square top edge
//  SQUARE_SIZE   in   SIZE_W             square edge length
//  BLOCK_X       in   NUM_BLOCKS*COORD_W packed left edges; slot i at [i*COORD_W +: COORD_W]
//  BLOCK_SHAPE   in   NUM_BLOCKS*SHAPE_W packed shape codes
//  BLOCK_VALID   in   NUM_BLOCKS         slot occupied
//  CLEAR_STICKY  in   1                  clears HIT, HIT_INDEX and HIT_COUNT
//  BUSY          out  1                  scan in progress
//  DONE          out  1                  one-cycle pulse when a scan completes
//  HIT           out  1                  collision found
//  HIT_INDEX     out  clog2(NUM_BLOCKS)  lowest colliding slot of the latest hitting scan
//  HIT_COUNT     out  clog2(NUM_BLOCKS+1) colliding slots found in the latest scan
// BEHAVIOUR
//  - Reset (async assert, sync deassert internally): FSM=IDLE; all outputs 0; snapshot regs 0.
//  - FSM states: IDLE -> SCAN on START. SCAN -> DONE_ST after slot NUM_BLOCKS-1, or on a hit
//    when EARLY_EXIT=1. DONE_ST -> IDLE unconditionally.
//  - START at cycle 0 latches all inputs. Slot k is judged in cycle k+1.
//    DONE rises in cycle NUM_BLOCKS+1 (EARLY_EXIT: cycle k+2 for first hit k).
//  - BUSY=1 in SCAN and DONE_ST. START while BUSY is ignored; it is not queued.
//  - Inputs changing mid-scan have no effect; only the snapshot is used.
//  - Slot judge, all arithmetic in COORD_W+1 bits (no wrap):
//      - x_ovl = SX < BX+BLOCK_W && SX+SIZE > BX. Touching edges do not overlap.
//      - Safe in gap g if SY >= GAP_LO[g] && SY+SIZE <= GAP_HI[g]. Empty gap entries (LO==HI) are never safe.
//      - hit = VALID && x_ovl && !(safe in any gap). An unknown shape code never hits.
//  - HIT_COUNT saturates at NUM_BLOCKS. HIT_INDEX takes the lowest hitting index; later hits do not overwrite it.
//  - STICKY=0: HIT/HIT_INDEX/HIT_COUNT clear when a new scan is accepted.
//  - STICKY=1: HIT stays set. HIT_COUNT still restarts each scan.
//  - CLEAR_STICKY takes effect when idle. If a hit is recorded in the same cycle, the hit wins.
//  - Reset mid-scan aborts the scan. No DONE pulse is issued.
// STRUCTURE
//  - collision_pkg: shape code constants, gap table as a function shape_gap(shape,g) returning
//    {lo,hi}, and widths shared with the renderer.
//  - Sub-module: block_gap_judge. Combinational single-slot judge, instantiated once and
//    time-multiplexed over the slot index mux.
//  - Top: FSM, slot counter, snapshot regs, result regs.
// TESTING  (shape 1 = single gap [200,300); BLOCK_W=40; NUM_BLOCKS=8)
//  - Square inside gap: SX=100,SY=220,SIZE=30, slot0 BX=90 shape1 valid
//    -> DONE at cycle 9, HIT=0, HIT_COUNT=0.
//  - Square clipping gap top: same setup with SY=190 -> HIT=1, HIT_INDEX=0, HIT_COUNT=1.
//  - Touching edge: SX=130,SIZE=30, BX=90 -> no x overlap, HIT=0.
//    Same case with SX=129 -> HIT=1.
//  - Multi-hit with EARLY_EXIT=0: slots 2 and 5 colliding -> HIT_INDEX=2, HIT_COUNT=2, DONE at cycle 9.
//    Same case with EARLY_EXIT=1 -> DONE at cycle 4, HIT_COUNT=1.
//  - Protocol: START during BUSY is ignored. STICKY=1 keeps HIT over a clean scan until CLEAR_STICKY.
//    RST_N low at cycle 4 -> all outputs 0 immediately, no DONE.

Source files
------------

// File: rtl/collision_pkg.sv
// Shared widths, shape codes and the obstacle gap table for the collision scan engine.
package collision_pkg;

  localparam int COORD_W_DEF  = 10;
  localparam int SIZE_W_DEF   = 6;
  localparam int SHAPE_W_DEF  = 4;
  localparam int MAX_GAPS_DEF = 2;
  localparam int BLOCK_W_DEF  = 40;
  localparam int GAP_W        = 10;
  localparam int NUM_SHAPES   = 4;

  // Shape codes understood by the renderer; anything at or above NUM_SHAPES is unknown.
  localparam logic [3:0] SHAPE_SOLID = 4'd0; // no gap at all
  localparam logic [3:0] SHAPE_MID   = 4'd1; // one gap [200,300)
  localparam logic [3:0] SHAPE_TWIN  = 4'd2; // gaps [100,180) and [320,400)
  localparam logic [3:0] SHAPE_SPLIT = 4'd3; // gaps [50,150) and [600,720)

  // One free vertical band; lo == hi marks an unused entry.
  typedef struct packed {
    logic [GAP_W-1:0] lo;
    logic [GAP_W-1:0] hi;
  } gap_t;

  function automatic logic shape_known(input logic [31:0] shape);
    return shape < 32'(NUM_SHAPES);
  endfunction

  function automatic gap_t shape_gap(input logic [31:0] shape, input logic [31:0] g);
    gap_t r;
    r = '{lo: '0, hi: '0};
    case (shape)
      32'(SHAPE_SOLID): r = '{lo: '0, hi: '0};
      32'(SHAPE_MID): begin
        if (g == 32'd0) r = '{lo: 10'd200, hi: 10'd300};
      end
      32'(SHAPE_TWIN): begin
        if (g == 32'd0)      r = '{lo: 10'd100, hi: 10'd180};
        else if (g == 32'd1) r = '{lo: 10'd320, hi: 10'd400};
      end
      32'(SHAPE_SPLIT): begin
        if (g == 32'd0)      r = '{lo: 10'd50,  hi: 10'd150};
        else if (g == 32'd1) r = '{lo: 10'd600, hi: 10'd720};
      end
      default: r = '{lo: '0, hi: '0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/collision_scan_engine_judge.sv
// Combinational single-slot judge: does the square collide with one obstacle slot?
module block_gap_judge
  import collision_pkg::*;
#(
  parameter int COORD_W  = COORD_W_DEF,
  parameter int SIZE_W   = SIZE_W_DEF,
  parameter int SHAPE_W  = SHAPE_W_DEF,
  parameter int MAX_GAPS = MAX_GAPS_DEF,
  parameter int BLOCK_W  = BLOCK_W_DEF
) (
  input  logic [COORD_W-1:0] i_sx,
  input  logic [COORD_W-1:0] i_sy,
  input  logic [SIZE_W-1:0]  i_size,
  input  logic [COORD_W-1:0] i_bx,
  input  logic [SHAPE_W-1:0] i_shape,
  input  logic               i_valid,
  output logic               o_hit
);

  // One extra bit so right/bottom edges never wrap.
  localparam int AW = COORD_W + 1;

  logic [AW-1:0] w_sx;
  logic [AW-1:0] w_sy;
  logic [AW-1:0] w_sx_end;
  logic [AW-1:0] w_sy_end;
  logic [AW-1:0] w_bx;
  logic [AW-1:0] w_bx_end;
  logic          w_x_ovl;
  logic          w_known;
  logic          w_safe;

  assign w_sx     = AW'(i_sx);
  assign w_sy     = AW'(i_sy);
  assign w_sx_end = w_sx + AW'(i_size);
  assign w_sy_end = w_sy + AW'(i_size);
  assign w_bx     = AW'(i_bx);
  assign w_bx_end = w_bx + AW'(BLOCK_W);

  // Strict compares: squares that merely touch the obstacle edge are clear.
  assign w_x_ovl = (w_sx < w_bx_end) && (w_sx_end > w_bx);
  assign w_known = shape_known(32'(i_shape));

  // The square is safe if it fits entirely inside any non-empty gap.
  always_comb begin
    gap_t          w_gap;
    logic [AW-1:0] w_lo;
    logic [AW-1:0] w_hi;
    w_safe = 1'b0;
    for (int g = 0; g < MAX_GAPS; g++) begin
      w_gap = shape_gap(32'(i_shape), 32'(g));
      w_lo  = AW'(w_gap.lo);
      w_hi  = AW'(w_gap.hi);
      if ((w_lo != w_hi) && (w_sy >= w_lo) && (w_sy_end <= w_hi)) w_safe = 1'b1;
    end
  end

  assign o_hit = i_valid && w_known && w_x_ovl && !w_safe;

endmodule

// File: rtl/collision_scan_engine.sv
// Sequential collision scanner: snapshots the square and all obstacle slots on start,
// then judges one slot per clock and reports first hit index, hit count and a hit flag.
// Handshake: i_start is a one-cycle request taken only when o_busy is low; o_done pulses
// for one cycle when results are stable and o_busy stays high through that cycle.
module collision_scan_engine
  import collision_pkg::*;
#(
  parameter int NUM_BLOCKS = 8,
  parameter int COORD_W    = COORD_W_DEF,
  parameter int SIZE_W     = SIZE_W_DEF,
  parameter int SHAPE_W    = SHAPE_W_DEF,
  parameter int MAX_GAPS   = MAX_GAPS_DEF,
  parameter int BLOCK_W    = BLOCK_W_DEF,
  parameter int EARLY_EXIT = 0,
  parameter int STICKY     = 1,
  parameter int IDX_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1,
  parameter int CNT_W      = $clog2(NUM_BLOCKS + 1)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_start,
  input  logic [COORD_W-1:0]            i_square_x,
  input  logic [COORD_W-1:0]            i_square_y,
  input  logic [SIZE_W-1:0]             i_square_size,
  input  logic [NUM_BLOCKS*COORD_W-1:0] i_block_x,
  input  logic [NUM_BLOCKS*SHAPE_W-1:0] i_block_shape,
  input  logic [NUM_BLOCKS-1:0]         i_block_valid,
  input  logic                          i_clear_sticky,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_hit,
  output logic [IDX_W-1:0]              o_hit_index,
  output logic [CNT_W-1:0]              o_hit_count,
  output logic [1:0]                    o_dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]                    r_rst_sync;
  logic                          w_rst_n;
  logic [1:0]                    r_state;
  logic [IDX_W-1:0]              r_idx;
  logic [COORD_W-1:0]            r_sx;
  logic [COORD_W-1:0]            r_sy;
  logic [SIZE_W-1:0]             r_size;
  logic [NUM_BLOCKS*COORD_W-1:0] r_block_x;
  logic [NUM_BLOCKS*SHAPE_W-1:0] r_block_shape;
  logic [NUM_BLOCKS-1:0]         r_block_valid;
  logic                          r_hit;
  logic [IDX_W-1:0]              r_hit_index;
  logic [CNT_W-1:0]              r_hit_count;

  logic                          w_accept;
  logic                          w_last;
  logic                          w_slot_hit;
  logic [COORD_W-1:0]            w_slot_bx;
  logic [SHAPE_W-1:0]            w_slot_shape;
  logic                          w_slot_valid;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_accept = (r_state == ST_IDLE) && i_start;
  assign w_last   = (r_idx == IDX_W'(NUM_BLOCKS - 1));

  // Slot index mux feeding the single shared judge.
  assign w_slot_bx    = r_block_x[r_idx*COORD_W +: COORD_W];
  assign w_slot_shape = r_block_shape[r_idx*SHAPE_W +: SHAPE_W];
  assign w_slot_valid = r_block_valid[r_idx];

  block_gap_judge #(
    .COORD_W  (COORD_W),
    .SIZE_W   (SIZE_W),
    .SHAPE_W  (SHAPE_W),
    .MAX_GAPS (MAX_GAPS),
    .BLOCK_W  (BLOCK_W)
  ) u_judge (
    .i_sx    (r_sx),
    .i_sy    (r_sy),
    .i_size  (r_size),
    .i_bx    (w_slot_bx),
    .i_shape (w_slot_shape),
    .i_valid (w_slot_valid),
    .o_hit   (w_slot_hit)
  );

  // Scan FSM and slot counter.
  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_SCAN;
            r_idx   <= '0;
          end
        end
        ST_SCAN: begin
          if (w_last || ((EARLY_EXIT != 0) && w_slot_hit)) r_state <= ST_DONE;
          else                                             r_idx   <= r_idx + IDX_W'(1);
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Input snapshot taken only when a scan is accepted.
  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sx          <= '0;
      r_sy          <= '0;
      r_size        <= '0;
      r_block_x     <= '0;
      r_block_shape <= '0;
      r_block_valid <= '0;
    end else if (w_accept) begin
      r_sx          <= i_square_x;
      r_sy          <= i_square_y;
      r_size        <= i_square_size;
      r_block_x     <= i_block_x;
      r_block_shape <= i_block_shape;
      r_block_valid <= i_block_valid;
    end
  end

  // Result registers; a zero count means this is the first hit of the current scan.
  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_hit       <= 1'b0;
      r_hit_index <= '0;
      r_hit_count <= '0;
    end else if (r_state == ST_IDLE) begin
      if (i_clear_sticky) begin
        r_hit       <= 1'b0;
        r_hit_index <= '0;
        r_hit_count <= '0;
      end
      if (i_start) begin
        r_hit_count <= '0;
        if (STICKY == 0) begin
          r_hit       <= 1'b0;
          r_hit_index <= '0;
        end
      end
    end else if ((r_state == ST_SCAN) && w_slot_hit) begin
      r_hit <= 1'b1;
      if (r_hit_count == '0) r_hit_index <= r_idx;
      if (r_hit_count != CNT_W'(NUM_BLOCKS)) r_hit_count <= r_hit_count + CNT_W'(1);
    end
  end

  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = (r_state == ST_DONE);
  assign o_hit       = r_hit;
  assign o_hit_index = r_hit_index;
  assign o_hit_count = r_hit_count;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_collision_scan_engine.sv
// Bench for collision_scan_engine: two instances (full scan + sticky, early exit + non-sticky)
// share one stimulus stream; expected results are queued at start and popped on each DONE.
module tb_collision_scan_engine;

  localparam int NB = 8;
  localparam int CW = 10;
  localparam int EW = 24; // {done_cycle[15:0], hit, index[2:0], count[3:0]}

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [CW-1:0]   square_x;
  logic [CW-1:0]   square_y;
  logic [5:0]      square_size;
  logic [NB*CW-1:0] block_x;
  logic [NB*4-1:0] block_shape;
  logic [NB-1:0]   block_valid;
  logic            clear_sticky;

  logic            busy_a, done_a, hit_a, busy_b, done_b, hit_b;
  logic [2:0]      idx_a, idx_b;
  logic [3:0]      cnt_a, cnt_b;
  logic [1:0]      dbg_a, dbg_b;

  int              cyc;
  int              checks;
  int              failures;
  int              last_t0;
  logic [EW-1:0]   exp_a_q[$];
  logic [EW-1:0]   exp_b_q[$];
  logic [EW-1:0]   e_a, e_b;

  // Stimulus staging and reference-model state.
  int              s_sx, s_sy, s_size;
  int              s_bx[NB];
  int              s_shape[NB];
  bit              s_valid[NB];
  bit              ma_hit;
  int              ma_idx;

  int gap_lo [4][2] = '{'{0, 0}, '{200, 0}, '{100, 320}, '{50, 600}};
  int gap_hi [4][2] = '{'{0, 0}, '{300, 0}, '{180, 400}, '{150, 720}};

  collision_scan_engine #(.NUM_BLOCKS(NB), .EARLY_EXIT(0), .STICKY(1)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_square_x(square_x), .i_square_y(square_y), .i_square_size(square_size),
    .i_block_x(block_x), .i_block_shape(block_shape), .i_block_valid(block_valid),
    .i_clear_sticky(clear_sticky),
    .o_busy(busy_a), .o_done(done_a), .o_hit(hit_a), .o_hit_index(idx_a),
    .o_hit_count(cnt_a), .o_dbg_state(dbg_a)
  );

  collision_scan_engine #(.NUM_BLOCKS(NB), .EARLY_EXIT(1), .STICKY(0)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_square_x(square_x), .i_square_y(square_y), .i_square_size(square_size),
    .i_block_x(block_x), .i_block_shape(block_shape), .i_block_valid(block_valid),
    .i_clear_sticky(clear_sticky),
    .o_busy(busy_b), .o_done(done_b), .o_hit(hit_b), .o_hit_index(idx_b),
    .o_hit_count(cnt_b), .o_dbg_state(dbg_b)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s act=%0d req=%0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference rule for one slot, straight from the geometric definition.
  function automatic bit judge_ref(int sx, int sy, int size, int bx, int shape, bit valid);
    bit safe;
    if (!valid || shape > 3) return 1'b0;
    if (!(sx < bx + 40 && sx + size > bx)) return 1'b0;
    safe = 1'b0;
    for (int g = 0; g < 2; g++)
      if (gap_lo[shape][g] != gap_hi[shape][g] && sy >= gap_lo[shape][g] &&
          sy + size <= gap_hi[shape][g]) safe = 1'b1;
    return !safe;
  endfunction

  // Monitors: pop one expectation per DONE pulse.
  always @(negedge clk) begin
    if (done_a) begin
      if (exp_a_q.size() == 0) chk("a_unexpected_done", 1, 0);
      else begin
        e_a = exp_a_q.pop_front();
        chk("a_done_cycle", cyc % 65536, int'(e_a[23:8]));
        chk("a_hit", int'(hit_a), int'(e_a[7]));
        chk("a_hit_index", int'(idx_a), int'(e_a[6:4]));
        chk("a_hit_count", int'(cnt_a), int'(e_a[3:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (done_b) begin
      if (exp_b_q.size() == 0) chk("b_unexpected_done", 1, 0);
      else begin
        e_b = exp_b_q.pop_front();
        chk("b_done_cycle", cyc % 65536, int'(e_b[23:8]));
        chk("b_hit", int'(hit_b), int'(e_b[7]));
        chk("b_hit_index", int'(idx_b), int'(e_b[6:4]));
        chk("b_hit_count", int'(cnt_b), int'(e_b[3:0]));
      end
    end
  end

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 100; i++) begin
      if (!busy_a && !busy_b) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!ok) chk("wait_idle_timeout", 1, 0);
  endtask

  task automatic scramble_inputs();
    square_x    = CW'($urandom);
    square_y    = CW'($urandom);
    square_size = 6'($urandom);
    for (int k = 0; k < NB; k++) block_x[k*CW +: CW] = CW'($urandom);
    block_shape = 32'($urandom);
    block_valid = 8'($urandom);
  endtask

  // Drives one scan request, queueing the expected result of each instance.
  task automatic issue_scan(input bit push, input bit dbl_start);
    int n, first, lat_b;
    bit any;
    wait_idle();
    n = 0; first = -1;
    for (int k = 0; k < NB; k++)
      if (judge_ref(s_sx, s_sy, s_size, s_bx[k], s_shape[k], s_valid[k])) begin
        n++;
        if (first < 0) first = k;
      end
    any = (n > 0);
    square_x    = CW'(s_sx);
    square_y    = CW'(s_sy);
    square_size = 6'(s_size);
    for (int k = 0; k < NB; k++) begin
      block_x[k*CW +: CW]  = CW'(s_bx[k]);
      block_shape[k*4 +: 4] = 4'(s_shape[k]);
      block_valid[k]       = s_valid[k];
    end
    start   = 1'b1;
    last_t0 = cyc;
    if (push) begin
      if (any) begin ma_hit = 1'b1; ma_idx = first; end
      exp_a_q.push_back({16'(last_t0 + NB + 1), ma_hit, 3'(ma_idx), 4'(n)});
      lat_b = any ? first + 2 : NB + 1;
      exp_b_q.push_back({16'(last_t0 + lat_b), any, 3'(any ? first : 0), 4'(any ? 1 : 0)});
    end
    @(posedge clk); #1;
    start = 1'b0;
    scramble_inputs();
    if (dbl_start) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic do_clear();
    wait_idle();
    clear_sticky = 1'b1;
    @(posedge clk); #1;
    clear_sticky = 1'b0;
    ma_hit = 1'b0; ma_idx = 0;
    chk("a_clear_hit", int'(hit_a), 0);
    chk("a_clear_index", int'(idx_a), 0);
    chk("a_clear_count", int'(cnt_a), 0);
    chk("b_clear_hit", int'(hit_b), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_a_busy"}, int'(busy_a), 0);
    chk({tag, "_a_done"}, int'(done_a), 0);
    chk({tag, "_a_hit"}, int'(hit_a), 0);
    chk({tag, "_a_index"}, int'(idx_a), 0);
    chk({tag, "_a_count"}, int'(cnt_a), 0);
    chk({tag, "_a_state"}, int'(dbg_a), 0);
    chk({tag, "_b_busy"}, int'(busy_b), 0);
    chk({tag, "_b_hit"}, int'(hit_b), 0);
    chk({tag, "_b_count"}, int'(cnt_b), 0);
  endtask

  // Single-obstacle setup: only slot `slot` occupied, others parked far away.
  task automatic setup_one(input int sx, input int sy, input int size, input int slot,
                           input int bx, input int shape);
    s_sx = sx; s_sy = sy; s_size = size;
    for (int k = 0; k < NB; k++) begin
      s_bx[k] = 700; s_shape[k] = 1; s_valid[k] = 1'b0;
    end
    s_bx[slot] = bx; s_shape[slot] = shape; s_valid[slot] = 1'b1;
  endtask

  task automatic gen_random();
    int v;
    s_sx   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 700));
    s_sy   = int'($urandom_range(0, 1023));
    if ($urandom_range(0, 1) == 1) s_sy = int'($urandom_range(40, 330));
    s_size = int'($urandom_range(1, 63));
    for (int k = 0; k < NB; k++) begin
      s_valid[k] = ($urandom_range(0, 3) != 0);
      s_shape[k] = int'($urandom_range(0, 5));
      if ($urandom_range(0, 1) == 1) begin
        v = s_sx + int'($urandom_range(0, 110)) - 75;
        if (v < 0) v = 0;
        if (v > 1023) v = 1023;
        s_bx[k] = v;
      end else s_bx[k] = int'($urandom_range(0, 1023));
    end
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0;
    ma_hit = 1'b0; ma_idx = 0;
    rst_n = 1'b1; start = 1'b0; clear_sticky = 1'b0;
    square_x = '0; square_y = '0; square_size = '0;
    block_x = '0; block_shape = '0; block_valid = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Square inside the gap, then clipping its top.
    setup_one(100, 220, 30, 0, 90, 1); issue_scan(1'b1, 1'b0);
    setup_one(100, 190, 30, 0, 90, 1); issue_scan(1'b1, 1'b0);
    // Touching right edge: clean scan, sticky flag on instance A survives.
    setup_one(130, 190, 30, 0, 90, 1); issue_scan(1'b1, 1'b0);
    do_clear();
    setup_one(129, 190, 30, 0, 90, 1); issue_scan(1'b1, 1'b0);
    // Slots 2 and 5 collide; unknown shape and touching solid block do not.
    setup_one(100, 190, 30, 2, 90, 1);
    s_bx[5] = 90;  s_shape[5] = 1; s_valid[5] = 1'b1;
    s_bx[3] = 90;  s_shape[3] = 9; s_valid[3] = 1'b1;
    s_bx[0] = 130; s_shape[0] = 0; s_valid[0] = 1'b1;
    issue_scan(1'b1, 1'b1);
    // Right-edge coordinates that would wrap in COORD_W bits.
    setup_one(1020, 100, 63, 7, 1000, 2); issue_scan(1'b1, 1'b0);

    for (int r = 0; r < 40; r++) begin
      gen_random();
      issue_scan(1'b1, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) do_clear();
    end

    // Reset in the middle of a scan: outputs drop at once, no DONE follows.
    setup_one(100, 190, 30, 6, 90, 1);
    issue_scan(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    ma_hit = 1'b0; ma_idx = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    setup_one(110, 250, 60, 4, 120, 1); issue_scan(1'b1, 1'b0);

    for (int i = 0; i < 200; i++) begin
      if (exp_a_q.size() == 0 && exp_b_q.size() == 0) break;
      @(posedge clk);
    end
    chk("a_pending_results", exp_a_q.size(), 0);
    chk("b_pending_results", exp_b_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
